mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency backend memory between the pipeline's instruction-fetch port (read-only) and data port (read/write).
- Sits between the pipeline datapath's two memory ports and the unified memory model/cache.
- Serialises accesses, gives data priority with a starvation guard for fetch, and returns per-requester ready pulses that the datapath uses as stall-release.
- Watchdog timeout converts a hung backend into a flagged, completed access.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises the pipeline's fetch and data ports onto one
// variable-latency backend memory. Data has priority, bounded by a streak
// limit so fetch cannot starve; a watchdog turns a hung access into a
// flagged completion with zero read data.
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ready,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 busy,
  output logic                 owner,
  output logic                 err
);

  localparam int unsigned TIMER_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]           state, state_nxt;
  logic [STREAK_W-1:0]  d_streak, d_streak_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic                 i_ready_nxt, d_ready_nxt;
  logic [WORD_SIZE-1:0] i_rdata_nxt, d_rdata_nxt;
  logic                 mem_read_nxt, mem_write_nxt;
  logic [WORD_SIZE-1:0] mem_addr_nxt, mem_wdata_nxt;
  logic                 busy_nxt, owner_nxt, err_nxt;
  logic                 d_grant;

  // Data wins unless fetch is waiting and data has used up its streak
  assign d_grant = d_req && !(i_req && (d_streak == STREAK_W'(MAX_D_STREAK)));

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    d_streak_nxt  = d_streak;
    timer_nxt     = timer;
    i_ready_nxt   = 1'b0;
    d_ready_nxt   = 1'b0;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
    mem_read_nxt  = mem_read;
    mem_write_nxt = mem_write;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    owner_nxt     = owner;
    err_nxt       = err;

    case (state)
      S_IDLE: begin
        if (!i_req) d_streak_nxt = '0;
        timer_nxt = '0;
        if (d_grant) begin
          owner_nxt    = 1'b1;
          mem_addr_nxt = d_addr;
          if (d_we) begin
            mem_write_nxt = 1'b1;
            mem_read_nxt  = 1'b0;
            mem_wdata_nxt = d_wdata;
          end else begin
            mem_write_nxt = 1'b0;
            mem_read_nxt  = 1'b1;
          end
          if (i_req && (d_streak < STREAK_W'(MAX_D_STREAK)))
            d_streak_nxt = d_streak + STREAK_W'(1);
          state_nxt = S_ACCESS;
        end else if (i_req) begin
          owner_nxt     = 1'b0;
          mem_addr_nxt  = i_addr;
          mem_read_nxt  = 1'b1;
          mem_write_nxt = 1'b0;
          d_streak_nxt  = '0;
          state_nxt     = S_ACCESS;
        end
      end

      S_ACCESS: begin
        timer_nxt = timer + TIMER_W'(1);
        if (mem_ack) begin
          if (!owner)        i_rdata_nxt = mem_rdata;
          else if (mem_read) d_rdata_nxt = mem_rdata;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          i_ready_nxt   = !owner;
          d_ready_nxt   = owner;
          state_nxt     = S_RESP;
        end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          if (!owner) i_rdata_nxt = '0;
          else        d_rdata_nxt = '0;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          err_nxt       = 1'b1;
          i_ready_nxt   = !owner;
          d_ready_nxt   = owner;
          state_nxt     = S_RESP;
        end
      end

      S_RESP: begin
        timer_nxt = '0;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      d_streak  <= '0;
      timer     <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      d_streak  <= d_streak_nxt;
      timer     <= timer_nxt;
      i_ready   <= i_ready_nxt;
      d_ready   <= d_ready_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      busy      <= busy_nxt;
      owner     <= owner_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// traffic against a transaction-level model of arbitration and memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_we, mem_ack;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ready, d_ready, mem_read, mem_write, busy, owner, err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  mem_port_arbiter #(.WORD_SIZE(16), .MAX_D_STREAK(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One access with immediate ack, starting from an IDLE cycle
  task automatic serve(input logic exp_own, input string tag);
    step();
    chk({tag, "_own"}, owner, exp_own);
    chk({tag, "_strb"}, mem_read | mem_write, 1);
    mem_ack   = 1'b1;
    mem_rdata = 16'($urandom);
    step();
    mem_ack = 1'b0;
    chk({tag, "_rdy"}, {i_ready, d_ready}, exp_own ? 2'b01 : 2'b10);
    step();
  endtask

  // Random-phase model state
  logic [15:0] mem_m [16];
  int          streak_m, wait_n, cnt;
  bit          idle_prev, resp_prev, acked_prev, resp_cur, acked_now, in_acc;
  bit          gi, gd, drop_i, drop_d;
  logic        exp_own, exp_we;
  logic [15:0] exp_addr, exp_wdata, exp_data, last_d;
  int unsigned d_cyc;

  initial begin
    reset_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    step(); step();
    chk("rst_outs", {i_ready, d_ready, mem_read, mem_write, busy, owner, err}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    reset_n = 1'b1;

    // Fetch only, ack on second strobe cycle
    i_req = 1; i_addr = 16'h0010;
    step();
    chk("t1_rd1", {mem_read, mem_write}, 2'b10);
    chk("t1_addr", mem_addr, 16'h0010);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_rd2", mem_read, 1);
    mem_ack = 1; mem_rdata = 16'hA5A5;
    step();
    mem_ack = 0; i_req = 0;
    chk("t1_rdy", {i_ready, d_ready, mem_read}, 3'b100);
    chk("t1_data", i_rdata, 16'hA5A5);
    step();
    chk("t1_idle", {i_ready, d_ready, busy}, 0);

    // Simultaneous requests: data write first, then fetch
    i_req = 1; i_addr = 16'h0030;
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
    step();
    chk("t2_wr", {mem_read, mem_write, owner}, 3'b011);
    chk("t2_addr", mem_addr, 16'h0020);
    chk("t2_wdata", mem_wdata, 16'h1234);
    mem_ack = 1;
    step();
    mem_ack = 0; d_req = 0;
    chk("t2_drdy", {i_ready, d_ready}, 2'b01);
    d_cyc = cyc;
    step();
    step();
    chk("t2_fetch", {mem_read, mem_write, owner}, 3'b100);
    chk("t2_faddr", mem_addr, 16'h0030);
    mem_ack = 1; mem_rdata = 16'h5555;
    step();
    mem_ack = 0; i_req = 0;
    chk("t2_irdy", {i_ready, d_ready}, 2'b10);
    chk("t2_gap", cyc - d_cyc, 3);
    chk("t2_idata", i_rdata, 16'h5555);
    step();

    // Starvation guard: four data grants, then fetch, then data again
    d_req = 1; d_we = 0; d_addr = 16'h0044; i_req = 1; i_addr = 16'h0088;
    for (int k = 0; k < 4; k++) serve(1'b1, "t3a");
    serve(1'b0, "t3f");
    i_req = 0;
    serve(1'b1, "t3b");
    i_req = 1;
    for (int k = 0; k < 4; k++) serve(1'b1, "t3c");
    serve(1'b0, "t3g");
    i_req = 0; d_req = 0;
    step();
    chk("t3_idle", busy, 0);

    // Backend never acks: watchdog completes the fetch
    i_req = 1; i_addr = 16'h0040;
    step();
    cnt = 0;
    while (mem_read && cnt < 100) begin
      cnt++;
      step();
    end
    i_req = 0;
    chk("t4_len", cnt, 64);
    chk("t4_rdy", i_ready, 1);
    chk("t4_data", i_rdata, 0);
    chk("t4_err", err, 1);
    step();
    d_req = 1; d_we = 1; d_addr = 16'h0002; d_wdata = 16'h7777;
    serve(1'b1, "t4s");
    d_req = 0;
    chk("t4_sticky", err, 1);

    // Reset in the middle of an access
    d_req = 1; d_we = 0; d_addr = 16'h0050;
    step();
    chk("t5_acc", mem_read, 1);
    reset_n = 0; d_req = 0;
    step();
    reset_n = 1;
    chk("t5_rst", {mem_read, mem_write, busy, err, d_ready, i_ready}, 0);
    mem_ack = 1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 0;
    chk("t5_ign", {d_ready, i_ready, busy}, 0);
    chk("t5_drd", d_rdata, 0);
    step();
    chk("t5_ign2", {d_ready, i_ready}, 0);

    // Ack on the last permitted cycle counts as success
    d_req = 1; d_we = 0; d_addr = 16'h0060;
    step();
    repeat (63) step();
    chk("t6_live", mem_read, 1);
    mem_ack = 1; mem_rdata = 16'h00FF;
    step();
    mem_ack = 0; d_req = 0;
    chk("t6_rdy", d_ready, 1);
    chk("t6_data", d_rdata, 16'h00FF);
    chk("t6_err", err, 0);
    step();

    // Randomized traffic against a transaction-level model
    reset_n = 0;
    step();
    reset_n = 1;
    for (int k = 0; k < 16; k++) mem_m[k] = 16'($urandom);
    streak_m = 0; idle_prev = 1; resp_prev = 0; acked_prev = 0; in_acc = 0;
    last_d = 0; exp_own = 0; exp_we = 0; exp_data = 0; exp_addr = 0; exp_wdata = 0;
    for (int n = 0; n < 800; n++) begin
      step();
      resp_cur = acked_prev;
      if (acked_prev) begin
        chk("r_rdy", {i_ready, d_ready}, exp_own ? 2'b01 : 2'b10);
        chk("r_strb", {mem_read, mem_write}, 0);
        if (!exp_own) chk("r_idata", i_rdata, exp_data);
        else begin
          if (!exp_we) last_d = exp_data;
          chk("r_ddata", d_rdata, last_d);
        end
      end else begin
        chk("r_quiet", {i_ready, d_ready}, 0);
      end
      gi = 0; gd = 0;
      if (idle_prev) begin
        if (d_req && !(i_req && streak_m == 4)) gd = 1;
        else if (i_req) gi = 1;
        if (!i_req) streak_m = 0;
        else if (gd) streak_m = (streak_m < 4) ? streak_m + 1 : 4;
        else if (gi) streak_m = 0;
        if (gd || gi) begin
          exp_own   = gd;
          exp_we    = gd ? d_we : 1'b0;
          exp_addr  = gd ? d_addr : i_addr;
          exp_wdata = d_wdata;
          chk("g_own", owner, exp_own);
          chk("g_addr", mem_addr, exp_addr);
          chk("g_strb", {mem_read, mem_write}, exp_we ? 2'b01 : 2'b10);
          if (exp_we) chk("g_wdata", mem_wdata, exp_wdata);
          chk("g_busy", busy, 1);
          in_acc = 1;
          wait_n = $urandom_range(0, 3);
        end else begin
          chk("g_none", {mem_read, mem_write, busy}, 0);
        end
      end
      // Backend response for this cycle
      acked_now = 0;
      if (in_acc) begin
        if (wait_n == 0) begin
          mem_ack = 1; acked_now = 1; in_acc = 0;
          if (exp_we) begin
            mem_m[exp_addr[3:0]] = exp_wdata;
            mem_rdata = 16'($urandom);
          end else begin
            exp_data = mem_m[exp_addr[3:0]];
            mem_rdata = exp_data;
          end
        end else begin
          wait_n--;
          mem_ack = 0;
          mem_rdata = 16'($urandom);
        end
      end else begin
        mem_ack = ($urandom_range(0, 7) == 0);
        mem_rdata = 16'($urandom);
      end
      // Requesters: hold while pending, renew or drop after completion
      drop_i = resp_cur && !exp_own;
      drop_d = resp_cur && exp_own;
      if (!i_req || drop_i) begin
        i_req  = ($urandom_range(0, 2) == 0);
        i_addr = 16'($urandom_range(0, 15));
      end
      if (!d_req || drop_d) begin
        d_req   = ($urandom_range(0, 1) == 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 16'($urandom_range(0, 15));
        d_wdata = 16'($urandom);
      end
      idle_prev  = resp_prev || (idle_prev && !(gi || gd));
      resp_prev  = resp_cur;
      acked_prev = acked_now;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
